// File: rtl/alu_issue_ctrl.sv
// Issue/collect stage in front of the four ALU units: one command in flight, decode to a
// one-cycle unit enable, capture the addressed unit's result. Optional macro: ALU_ISSUE_OPCNT_EN.
module alu_issue_ctrl #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [A_WIDTH-1:0]   cmd_a,
    input  logic [B_WIDTH-1:0]   cmd_b,
    input  logic [3:0]           cmd_fun,
    output logic [A_WIDTH-1:0]   A,
    output logic [B_WIDTH-1:0]   B,
    output logic [3:0]           ALU_FUN,
    output logic                 ARITH_Enable,
    output logic                 LOGIC_Enable,
    output logic                 CMP_Enable,
    output logic                 SHIFT_Enable,
    input  logic [OUT_WIDTH-1:0] arith_out,
    input  logic [OUT_WIDTH-1:0] logic_out,
    input  logic [OUT_WIDTH-1:0] cmp_out,
    input  logic [OUT_WIDTH-1:0] shift_out,
    input  logic                 arith_flag,
    input  logic                 logic_flag,
    input  logic                 cmp_flag,
    input  logic                 shift_flag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic                 res_flag,
`ifdef ALU_ISSUE_OPCNT_EN
    output logic [CNT_WIDTH-1:0] op_count,
    input  logic                 op_count_clr,
`endif
    output logic [1:0]           res_unit
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t               state;
    logic [OUT_WIDTH-1:0] sel_out;
    logic                 sel_flag;

    assign cmd_ready = (state == IDLE);

    // Units clear their outputs when disabled, so the mux must be sampled in WAIT.
    always_comb begin
        sel_out  = arith_out;
        sel_flag = arith_flag;
        case (ALU_FUN[3:2])
            2'b00: begin sel_out = arith_out; sel_flag = arith_flag; end
            2'b01: begin sel_out = logic_out; sel_flag = logic_flag; end
            2'b10: begin sel_out = cmp_out;   sel_flag = cmp_flag;   end
            2'b11: begin sel_out = shift_out; sel_flag = shift_flag; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            A            <= '0;
            B            <= '0;
            ALU_FUN      <= '0;
            ARITH_Enable <= 1'b0;
            LOGIC_Enable <= 1'b0;
            CMP_Enable   <= 1'b0;
            SHIFT_Enable <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_flag     <= 1'b0;
            res_unit     <= '0;
        end else begin
            ARITH_Enable <= 1'b0;
            LOGIC_Enable <= 1'b0;
            CMP_Enable   <= 1'b0;
            SHIFT_Enable <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    A            <= cmd_a;
                    B            <= cmd_b;
                    ALU_FUN      <= cmd_fun;
                    ARITH_Enable <= (cmd_fun[3:2] == 2'b00);
                    LOGIC_Enable <= (cmd_fun[3:2] == 2'b01);
                    CMP_Enable   <= (cmd_fun[3:2] == 2'b10);
                    SHIFT_Enable <= (cmd_fun[3:2] == 2'b11);
                    state        <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    res_data  <= sel_out;
                    res_flag  <= sel_flag;
                    res_unit  <= ALU_FUN[3:2];
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_OPCNT_EN
    // Counts result handshakes, saturating; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            op_count <= '0;
        else if (op_count_clr)
            op_count <= '0;
        else if (res_valid && res_ready && (op_count != {CNT_WIDTH{1'b1}}))
            op_count <= op_count + 1'b1;
    end
`endif

endmodule
